// File: rtl/signed_divider_adapter.sv
// signed_divider_adapter: signed/unsigned request front end for the unsigned divider core
module signed_divider_adapter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clk_en_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic                  signed_i,
  output logic [DATA_WIDTH-1:0] core_dividend_o,
  output logic [DATA_WIDTH-1:0] core_divisor_o,
  output logic                  core_valid_o,
  input  logic [DATA_WIDTH-1:0] core_quotient_i,
  input  logic [DATA_WIDTH-1:0] core_remainder_i,
  input  logic                  core_valid_i,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o,
  output logic                  divide_by_zero_o,
  output logic                  overflow_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i
);
  localparam logic [DATA_WIDTH-1:0] MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;
  state_t state;
  logic neg_q, neg_r, neg_a, neg_b, dz, ov;
  always_comb begin
    neg_a = signed_i & dividend_i[DATA_WIDTH-1];
    neg_b = signed_i & divisor_i[DATA_WIDTH-1];
    dz    = divisor_i == '0;
    ov    = signed_i && dividend_i == MIN && divisor_i == '1;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state            <= S_IDLE;
      req_ready_o      <= 1'b1;
      core_valid_o     <= 1'b0;
      res_valid_o      <= 1'b0;
      divide_by_zero_o <= 1'b0;
      overflow_o       <= 1'b0;
      quotient_o       <= '0;
      remainder_o      <= '0;
      core_dividend_o  <= '0;
      core_divisor_o   <= '0;
      neg_q            <= 1'b0;
      neg_r            <= 1'b0;
    end else if (clk_en_i)
      case (state)
        S_IDLE:
          if (req_valid_i) begin
            req_ready_o      <= 1'b0;
            divide_by_zero_o <= dz;
            overflow_o       <= ov;
            if (dz || ov) begin
              quotient_o  <= dz ? '1 : MIN;
              remainder_o <= dz ? dividend_i : '0;
              res_valid_o <= 1'b1;
              state       <= S_HOLD;
            end else begin
              core_dividend_o <= neg_a ? -dividend_i : dividend_i;
              core_divisor_o  <= neg_b ? -divisor_i : divisor_i;
              neg_q           <= neg_a ^ neg_b;
              neg_r           <= neg_a;
              core_valid_o    <= 1'b1;
              state           <= S_ISSUE;
            end
          end
        S_ISSUE: begin
          core_valid_o <= 1'b0;
          state        <= S_WAIT;
        end
        S_WAIT:
          if (core_valid_i) begin
            quotient_o  <= neg_q ? -core_quotient_i : core_quotient_i;
            remainder_o <= neg_r ? -core_remainder_i : core_remainder_i;
            res_valid_o <= 1'b1;
            state       <= S_HOLD;
          end
        default:
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= S_IDLE;
          end
      endcase
endmodule

// File: tb/tb_signed_divider_adapter.sv
// tb_signed_divider_adapter: randomized and directed checks against a reference divide model
module tb_signed_divider_adapter;
  localparam int W = 16;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  logic clk_i = 0, rst_i = 1, clk_en_i = 1, req_valid_i = 0, signed_i = 0, res_ready_i = 0;
  logic [W-1:0] dividend_i = 0, divisor_i = 0;
  logic req_ready_o, core_valid_o, divide_by_zero_o, overflow_o, res_valid_o;
  logic [W-1:0] core_dividend_o, core_divisor_o, quotient_o, remainder_o;
  logic [W-1:0] cq = 0, cr = 0, ca = 0, cb = 1;
  logic core_v = 0, spur = 0;
  int cnt = 0, pulses = 0, checks = 0, errors = 0;
  always #5 clk_i = ~clk_i;
  signed_divider_adapter #(.DATA_WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .signed_i(signed_i),
    .core_dividend_o(core_dividend_o), .core_divisor_o(core_divisor_o), .core_valid_o(core_valid_o),
    .core_quotient_i(cq), .core_remainder_i(cr), .core_valid_i(core_v | spur),
    .quotient_o(quotient_o), .remainder_o(remainder_o),
    .divide_by_zero_o(divide_by_zero_o), .overflow_o(overflow_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i));
  // core model: result strobe W+2 enabled cycles after the start pulse is sampled
  always @(posedge clk_i)
    if (rst_i) begin
      cnt <= 0;
      core_v <= 0;
    end else if (clk_en_i) begin
      core_v <= 0;
      if (core_valid_o) begin
        cnt <= W + 1;
        ca <= core_dividend_o;
        cb <= core_divisor_o;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          core_v <= 1;
          cq <= ca / cb;
          cr <= ca % cb;
        end
      end
    end
  always @(posedge clk_i) if (clk_en_i && !rst_i && core_valid_o) pulses++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz, output logic ov);
    longint sa, sb, tq, tr;
    dz = 0;
    ov = 0;
    if (b == 0) begin
      q = '1; r = a; dz = 1;
    end else if (s && a == MIN && b == '1) begin
      q = MIN; r = 0; ov = 1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      tq = sa / sb;
      tr = sa % sb;
      q = tq[W-1:0];
      r = tr[W-1:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask
  task automatic xact(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input int hold, input int stall_at);
    logic [W-1:0] eq, er;
    logic edz, eov, byp;
    int lat, p0, elat;
    ref_div(a, b, s, eq, er, edz, eov);
    byp = edz | eov;
    elat = byp ? 1 : W + 4 + (stall_at > 0 ? 5 : 0);
    chk("req_ready_idle", 32'(req_ready_o), 1);
    req_valid_i = 1; dividend_i = a; divisor_i = b; signed_i = s; p0 = pulses;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 0;
    lat = 1;
    while (!res_valid_o && lat < 100) begin
      if (lat == stall_at) clk_en_i = 0;
      if (lat == stall_at + 5) clk_en_i = 1;
      @(negedge clk_i);
      lat++;
    end
    clk_en_i = 1;
    chk("latency", lat, elat);
    chk("core_pulses", pulses - p0, byp ? 0 : 1);
    chk("quotient", 32'(quotient_o), 32'(eq));
    chk("remainder", 32'(remainder_o), 32'(er));
    chk("div_by_zero", 32'(divide_by_zero_o), 32'(edz));
    chk("overflow", 32'(overflow_o), 32'(eov));
    for (int i = 0; i < hold; i++) begin
      req_valid_i = 1; dividend_i = ~a; divisor_i = 3; spur = (i == 0);
      @(negedge clk_i);
      spur = 0;
      chk("hold_valid", 32'(res_valid_o), 1);
      chk("hold_ready", 32'(req_ready_o), 0);
      chk("hold_q", 32'(quotient_o), 32'(eq));
      chk("hold_r", 32'(remainder_o), 32'(er));
      chk("hold_flags", 32'({divide_by_zero_o, overflow_o}), 32'({edz, eov}));
    end
    req_valid_i = 0;
    chk("hold_no_pulse", pulses - p0, byp ? 0 : 1);
    res_ready_i = 1;
    @(negedge clk_i);
    res_ready_i = 0;
    chk("release_valid", 32'(res_valid_o), 0);
    chk("release_ready", 32'(req_ready_o), 1);
  endtask
  initial begin
    logic [W-1:0] a, b;
    logic s;
    int rose;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", 32'(req_ready_o), 1);
    chk("rst_valids", 32'({core_valid_o, res_valid_o, divide_by_zero_o, overflow_o}), 0);
    chk("rst_data", 32'({quotient_o, remainder_o}), 0);
    chk("rst_core_ops", 32'({core_dividend_o, core_divisor_o}), 0);
    rst_i = 0;
    @(negedge clk_i);
    xact(100, 7, 0, 0, 0);
    xact(16'hFFF9, 16'h0002, 1, 0, 0);
    xact(16'h0007, 16'hFFFE, 1, 0, 0);
    xact(16'hFFFB, 16'h0000, 1, 0, 0);
    xact(16'h1234, 16'h0000, 0, 0, 0);
    xact(16'h8000, 16'hFFFF, 1, 0, 0);
    xact(16'h8000, 16'hFFFF, 0, 0, 0);
    xact(16'h8000, 16'h0001, 1, 0, 0);
    xact(16'h4321, 16'h0013, 0, 10, 0);
    xact(16'hFFFB, 16'h0000, 1, 10, 0);
    xact(16'hF00D, 16'h0021, 1, 0, 8);
    req_valid_i = 1; dividend_i = 1000; divisor_i = 3; signed_i = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 0;
    repeat (8) @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    chk("midrst_ready", 32'(req_ready_o), 1);
    chk("midrst_valids", 32'({core_valid_o, res_valid_o, divide_by_zero_o, overflow_o}), 0);
    chk("midrst_data", 32'({quotient_o, remainder_o}), 0);
    chk("midrst_core_ops", 32'({core_dividend_o, core_divisor_o}), 0);
    rose = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (res_valid_o) rose++;
    end
    chk("midrst_no_result", rose, 0);
    xact(16'hFC18, 16'h0007, 1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      s = 1'($urandom);
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = MIN; b = '1; end
        2: b = W'($urandom_range(1, 9));
        3: b = -W'($urandom_range(1, 9));
        default: ;
      endcase
      xact(a, b, s, $urandom_range(0, 2), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/signed_divider_adapter.md
# signed_divider_adapter

Request/response front end for the unsigned non-restoring divider core. Accepts signed or unsigned operand pairs over a valid/ready handshake and converts signed operands to magnitudes. Drives the core's one-cycle start pulse, captures the core's one-cycle result strobe, applies sign correction and holds the result until the consumer takes it. Divide-by-zero and signed overflow are resolved locally, without the core.

## Interface
- DATA_WIDTH, 16, operand/result width; power of 2, ≥ 4; must equal the core's DATA_WIDTH
- clk_i  in  1  clock, shared with the core
- rst_i  in  1  reset, synchronous, active-high; integration drives core rst_n_i = ~rst_i
- clk_en_i  in  1  clock enable; low freezes every register; same net as core clk_en_i
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- dividend_i  in  DATA_WIDTH  dividend
- divisor_i  in  DATA_WIDTH  divisor
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned
- core_dividend_o  out  DATA_WIDTH  magnitude to core
- core_divisor_o  out  DATA_WIDTH  magnitude to core
- core_valid_o  out  1  core start pulse
- core_quotient_i  in  DATA_WIDTH  core quotient
- core_remainder_i  in  DATA_WIDTH  core remainder
- core_valid_i  in  1  core result strobe, one cycle
- quotient_o  out  DATA_WIDTH  final quotient
- remainder_o  out  DATA_WIDTH  final remainder
- divide_by_zero_o  out  1  divisor was zero
- overflow_o  out  1  signed MIN / -1
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumed

## Operation
- FSM states and transitions:
  - IDLE: req_ready_o = 1. On req_valid_i, capture operands and flags.
  - From IDLE, normal case: go to ISSUE.
  - From IDLE, divisor == 0 or (signed_i and dividend == MIN and divisor == all-ones): go directly to HOLD (bypass).
  - ISSUE: core_valid_o = 1 for exactly one cycle, then go to WAIT.
  - WAIT: on core_valid_i, capture core results, apply sign correction, go to HOLD.
  - HOLD: res_valid_o = 1. On res_ready_i, go to IDLE.
- Magnitudes:
  - If signed_i and operand MSB = 1, send the two's-complement negation of the operand; otherwise send the operand unchanged.
  - MIN negates to itself, which is the correct unsigned magnitude 2^(W-1).
- Sign correction, signed only:
  - Quotient is negated when sign(dividend) XOR sign(divisor).
  - Remainder is negated when sign(dividend) = 1 (remainder takes the sign of the dividend).
  - Unsigned requests pass core results unchanged.
- Divide by zero: quotient_o = all-ones, remainder_o = dividend_i as given, divide_by_zero_o = 1, overflow_o = 0. This applies to both signed and unsigned requests.
- Signed overflow: quotient_o = MIN, remainder_o = 0, overflow_o = 1, divide_by_zero_o = 0.
- Flags are 0 for normal results.
- core_dividend_o and core_divisor_o are registered and stay stable from ISSUE through WAIT.
- core_valid_i outside WAIT is ignored.
- Only one request is in flight; there is no queueing.

## Timing
- Reset values:
  - state = IDLE, req_ready_o = 1.
  - core_valid_o, res_valid_o, divide_by_zero_o and overflow_o = 0.
  - quotient_o, remainder_o, core_dividend_o and core_divisor_o = 0.
- Cycle numbering (acceptance edge ends cycle 0):
  - Cycle 1: ISSUE, core_valid_o = 1.
  - Core runs DATA_WIDTH DIVIDE cycles plus one RESTORE cycle.
  - core_valid_i is high in cycle DATA_WIDTH + 3.
  - res_valid_o rises in cycle DATA_WIDTH + 4 (cycle 20 for W = 16).
- Bypass latency: res_valid_o is high in cycle 1.
- Result hold: outputs and flags are stable while res_valid_o = 1 and res_ready_i = 0.
- Release: the HOLD→IDLE edge clears res_valid_o; req_ready_o = 1 in the following cycle.
- Minimum request spacing: DATA_WIDTH + 5 cycles when res_ready_i is tied high.
- clk_en_i = 0 stalls the adapter and the core together; cycle counts are in enabled cycles.
- rst_i mid-operation (any state): IDLE on the next edge, pending result discarded. The core is reset through the integration inversion, so no stale core_valid_i follows.
- req_valid_i is ignored when req_ready_o = 0.

## Test plan
- Unsigned, 100 / 7 → quotient 14, remainder 2, flags 0, res_valid_o in cycle 20 after acceptance.
- Signed, 0xFFF9 / 0x0002 (-7 / 2) → quotient 0xFFFD, remainder 0xFFFF. Then 0x0007 / 0xFFFE (7 / -2) → quotient 0xFFFD, remainder 0x0001.
- Signed, 0xFFFB / 0 → quotient 0xFFFF, remainder 0xFFFB, divide_by_zero_o = 1, res_valid_o in cycle 1, core_valid_o never pulses.
- Signed, 0x8000 / 0xFFFF → quotient 0x8000, remainder 0, overflow_o = 1, bypass latency. The same operands unsigned → quotient 0, remainder 0x8000, flags 0.
- Backpressure: hold res_ready_i low for 10 cycles after res_valid_o → outputs stable, req_ready_o = 0, new req_valid_i ignored. Then pulse res_ready_i → req_ready_o = 1 in the next cycle.
- Reset and clock-enable disturbances:
  - Assert rst_i for one cycle during WAIT → all outputs at reset values, no result emitted, and the next request completes correctly.
  - Hold clk_en_i low for 5 cycles mid-WAIT → latency extends by exactly 5.
